// File: rtl/branch_ctrl_pkg.sv
// Purpose: shared codes, state encoding and target helper for ID-stage branch resolution.
// Latency: none; definitions only.
// Backpressure: not applicable.
package branch_ctrl_pkg;

  // Comparator result codes
  localparam logic [1:0] BRANCH_DEFAULT = 2'b00;
  localparam logic [1:0] BRANCH_EQUAL   = 2'b01;
  localparam logic [1:0] BRANCH_LT      = 2'b10;
  localparam logic [1:0] BRANCH_GT      = 2'b11;

  // Branch condition encodings; 6 and 7 are reserved and never taken
  localparam int unsigned BR_COND_W = 3;
  localparam logic [BR_COND_W-1:0] BR_COND_BEQ  = 3'd0;
  localparam logic [BR_COND_W-1:0] BR_COND_BNE  = 3'd1;
  localparam logic [BR_COND_W-1:0] BR_COND_BLTZ = 3'd2;
  localparam logic [BR_COND_W-1:0] BR_COND_BGTZ = 3'd3;
  localparam logic [BR_COND_W-1:0] BR_COND_BLEZ = 3'd4;
  localparam logic [BR_COND_W-1:0] BR_COND_BGEZ = 3'd5;

  // Controller states
  typedef enum logic [1:0] {
    BRC_IDLE  = 2'd0,
    BRC_WAIT  = 2'd1,
    BRC_ISSUE = 2'd2
  } brc_state_e;

  // Branch target: base is the delay-slot PC, word offset scaled to bytes, wraps mod 2^32
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] offset);
    return pc + 32'd4 + {offset[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Purpose: decide taken/not-taken from a branch condition and the comparator code.
// Latency: combinational.
// Backpressure: none.
module branch_cond_eval
  import branch_ctrl_pkg::*;
(
  input  logic [BR_COND_W-1:0] br_cond,
  input  logic [1:0]           cmp_result,
  output logic                 taken
);

  // Map each condition to the comparator codes that make it taken
  always_comb begin
    taken = 1'b0;
    case (br_cond)
      BR_COND_BEQ:  taken = (cmp_result == BRANCH_EQUAL);
      BR_COND_BNE:  taken = (cmp_result == BRANCH_LT) || (cmp_result == BRANCH_GT);
      BR_COND_BLTZ: taken = (cmp_result == BRANCH_LT);
      BR_COND_BGTZ: taken = (cmp_result == BRANCH_GT);
      BR_COND_BLEZ: taken = (cmp_result == BRANCH_EQUAL) || (cmp_result == BRANCH_LT);
      BR_COND_BGEZ: taken = (cmp_result == BRANCH_EQUAL) || (cmp_result == BRANCH_GT);
      default:      taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Purpose: sequence ID-stage branch resolution and issue a registered redirect to fetch.
// Latency: redirect one cycle after operands are ready; operand wait bounded by MAX_WAIT.
// Backpressure: stall_id holds IF/ID while unresolved. Optional BRANCH_DELAY_SLOT_EN keeps flush_if at 0.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 br_valid,
  input  logic [BR_COND_W-1:0] br_cond,
  input  logic [31:0]          br_pc,
  input  logic [31:0]          br_offset,
  input  logic                 opnd_ready,
  input  logic [1:0]           cmp_result,
  input  logic                 ex_flush,
  output logic                 stall_id,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 flush_if,
  output logic                 br_taken,
  output logic                 br_resolved,
  output logic                 wait_err
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  brc_state_e           state_q, state_d;
  logic [3:0]           wait_cnt_q, wait_cnt_d;
  logic [BR_COND_W-1:0] cond_q, cond_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          offset_q, offset_d;
  logic                 redirect_valid_q, redirect_valid_d;
  logic [31:0]          redirect_pc_q, redirect_pc_d;
  logic                 flush_if_q, flush_if_d;
  logic                 br_taken_q, br_taken_d;
  logic                 br_resolved_q, br_resolved_d;
  logic                 wait_err_q, wait_err_d;

  logic [BR_COND_W-1:0] eval_cond;
  logic [31:0]          eval_target;
  logic                 eval_taken;
  logic                 issue_now;

  // In WAIT the latched branch is evaluated; in IDLE the incoming one is
  assign eval_cond   = (state_q == BRC_WAIT) ? cond_q : br_cond;
  assign eval_target = (state_q == BRC_WAIT) ? branch_target(pc_q, offset_q)
                                             : branch_target(br_pc, br_offset);

  branch_cond_eval u_cond_eval (
    .br_cond    (eval_cond),
    .cmp_result (cmp_result),
    .taken      (eval_taken)
  );

  // Next-state, latch and single-cycle output pulse computation; flush overrides all
  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    cond_d           = cond_q;
    pc_d             = pc_q;
    offset_d         = offset_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = 32'h0;
    flush_if_d       = 1'b0;
    br_taken_d       = 1'b0;
    br_resolved_d    = 1'b0;
    wait_err_d       = 1'b0;
    issue_now        = 1'b0;

    case (state_q)
      BRC_IDLE: begin
        if (br_valid) begin
          cond_d   = br_cond;
          pc_d     = br_pc;
          offset_d = br_offset;
          if (opnd_ready) begin
            issue_now  = 1'b1;
            state_d    = BRC_ISSUE;
            wait_cnt_d = 4'd0;
          end else begin
            state_d    = BRC_WAIT;
            wait_cnt_d = 4'd1;
          end
        end
      end
      BRC_WAIT: begin
        if (opnd_ready) begin
          issue_now  = 1'b1;
          state_d    = BRC_ISSUE;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q == MAX_WAIT_C) begin
          wait_err_d = 1'b1;
          state_d    = BRC_IDLE;
          wait_cnt_d = 4'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      BRC_ISSUE: state_d = BRC_IDLE;
      default:   state_d = BRC_IDLE;
    endcase

    if (issue_now) begin
      br_resolved_d    = 1'b1;
      br_taken_d       = eval_taken;
      redirect_valid_d = eval_taken;
      redirect_pc_d    = eval_taken ? eval_target : 32'h0;
`ifdef BRANCH_DELAY_SLOT_EN
      flush_if_d       = 1'b0;
`else
      flush_if_d       = eval_taken;
`endif
    end

    if (ex_flush) begin
      state_d          = BRC_IDLE;
      wait_cnt_d       = 4'd0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = 32'h0;
      flush_if_d       = 1'b0;
      br_taken_d       = 1'b0;
      br_resolved_d    = 1'b0;
      wait_err_d       = 1'b0;
    end
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= BRC_IDLE;
      wait_cnt_q       <= 4'd0;
      cond_q           <= '0;
      pc_q             <= 32'h0;
      offset_q         <= 32'h0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
      flush_if_q       <= 1'b0;
      br_taken_q       <= 1'b0;
      br_resolved_q    <= 1'b0;
      wait_err_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      cond_q           <= cond_d;
      pc_q             <= pc_d;
      offset_q         <= offset_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_if_q       <= flush_if_d;
      br_taken_q       <= br_taken_d;
      br_resolved_q    <= br_resolved_d;
      wait_err_q       <= wait_err_d;
    end
  end

  assign stall_id       = !ex_flush && (((state_q == BRC_IDLE) && br_valid) || (state_q == BRC_WAIT));
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_if       = flush_if_q;
  assign br_taken       = br_taken_q;
  assign br_resolved    = br_resolved_q;
  assign wait_err       = wait_err_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Purpose: self-checking bench for branch_ctrl against a table-driven outcome model.
// Latency: inputs driven 1ns after rising edge, outputs sampled on falling edge.
// Backpressure: not applicable.
module tb_branch_ctrl;

  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic        opnd_ready;
  logic [1:0]  cmp_result;
  logic        ex_flush;
  logic        stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if;
  logic        br_taken;
  logic        br_resolved;
  logic        wait_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk            (clk),
    .rst            (rst),
    .br_valid       (br_valid),
    .br_cond        (br_cond),
    .br_pc          (br_pc),
    .br_offset      (br_offset),
    .opnd_ready     (opnd_ready),
    .cmp_result     (cmp_result),
    .ex_flush       (ex_flush),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if       (flush_if),
    .br_taken       (br_taken),
    .br_resolved    (br_resolved),
    .wait_err       (wait_err)
  );

  // Outcome table: bit c of the mask is set when comparator code c makes the condition taken
  function automatic logic ref_taken(input int cond, input int cmp);
    logic [3:0] m;
    case (cond)
      0: m = 4'b0010;
      1: m = 4'b1100;
      2: m = 4'b0100;
      3: m = 4'b1000;
      4: m = 4'b0110;
      5: m = 4'b1010;
      default: m = 4'b0000;
    endcase
    return m[cmp];
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [31:0] off);
    longint t;
    t = longint'(pc) + 64'sd4 + longint'($signed(off)) * 64'sd4;
    return t[31:0];
  endfunction

  function automatic logic ref_flush(input logic taken);
`ifdef BRANCH_DELAY_SLOT_EN
    return 1'b0;
`else
    return taken;
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br_valid   = 1'b0;
    opnd_ready = 1'b0;
    ex_flush   = 1'b0;
    cmp_result = 2'($urandom);
  endtask

  // One branch through the controller; nw not-ready cycles, nw > MAX_WAIT means overrun
  task automatic drive_branch(input int cond, input int cmp, input logic [31:0] pc,
                              input logic [31:0] off, input int nw, input string name);
    logic        exp_t;
    logic [31:0] exp_pc;
    int          nr;
    exp_t  = ref_taken(cond, cmp);
    exp_pc = ref_target(pc, off);
    nr     = (nw > MAX_WAIT) ? MAX_WAIT + 1 : nw;
    for (int k = 0; k < nr; k++) begin
      br_valid = 1'b1; opnd_ready = 1'b0; ex_flush = 1'b0; cmp_result = 2'($urandom);
      if (k == 0) begin
        br_cond = 3'(cond); br_pc = pc; br_offset = off;
      end else begin
        br_cond = 3'($urandom); br_pc = $urandom; br_offset = $urandom;
      end
      @(negedge clk);
      checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL %s wait%0d stall_id got %0b want 1", name, k, stall_id); end
      checks++; if (br_resolved !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL %s wait%0d early resolve/redirect got %0b/%0b want 0/0", name, k, br_resolved, redirect_valid); end
      next_cycle();
    end
    if (nw > MAX_WAIT) begin
      idle_inputs();
      @(negedge clk);
      checks++; if (wait_err !== 1'b1) begin errors++; $display("FAIL %s wait_err got %0b want 1", name, wait_err); end
      checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL %s overrun stall_id got %0b want 0", name, stall_id); end
      checks++; if (br_resolved !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL %s overrun resolve/redirect got %0b/%0b want 0/0", name, br_resolved, redirect_valid); end
      next_cycle();
      @(negedge clk);
      checks++; if (wait_err !== 1'b0) begin errors++; $display("FAIL %s wait_err pulse width got %0b want 0", name, wait_err); end
      next_cycle();
      return;
    end
    br_valid = 1'b1; opnd_ready = 1'b1; ex_flush = 1'b0; cmp_result = 2'(cmp);
    if (nw == 0) begin
      br_cond = 3'(cond); br_pc = pc; br_offset = off;
    end else begin
      br_cond = 3'($urandom); br_pc = $urandom; br_offset = $urandom;
    end
    @(negedge clk);
    checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL %s ready stall_id got %0b want 1", name, stall_id); end
    checks++; if (br_resolved !== 1'b0) begin errors++; $display("FAIL %s ready br_resolved got %0b want 0", name, br_resolved); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL %s issue stall_id got %0b want 0", name, stall_id); end
    checks++; if (br_resolved !== 1'b1) begin errors++; $display("FAIL %s br_resolved got %0b want 1", name, br_resolved); end
    checks++; if (br_taken !== exp_t) begin errors++; $display("FAIL %s br_taken got %0b want %0b", name, br_taken, exp_t); end
    checks++; if (redirect_valid !== exp_t) begin errors++; $display("FAIL %s redirect_valid got %0b want %0b", name, redirect_valid, exp_t); end
    checks++; if (flush_if !== ref_flush(exp_t)) begin errors++; $display("FAIL %s flush_if got %0b want %0b", name, flush_if, ref_flush(exp_t)); end
    checks++; if (wait_err !== 1'b0) begin errors++; $display("FAIL %s wait_err got %0b want 0", name, wait_err); end
    if (exp_t) begin
      checks++; if (redirect_pc !== exp_pc) begin errors++; $display("FAIL %s redirect_pc got %08h want %08h", name, redirect_pc, exp_pc); end
    end
    next_cycle();
    @(negedge clk);
    checks++; if (br_resolved !== 1'b0 || redirect_valid !== 1'b0 || flush_if !== 1'b0) begin errors++; $display("FAIL %s pulse held got res=%0b rv=%0b fl=%0b want 0", name, br_resolved, redirect_valid, flush_if); end
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); br_cond = 3'd0; br_pc = 32'h0; br_offset = 32'h0;
    next_cycle(); next_cycle();
    @(negedge clk);
    checks++; if ({redirect_valid, flush_if, br_taken, br_resolved, wait_err, stall_id} !== 6'b0) begin errors++; $display("FAIL reset outputs got %06b want 000000", {redirect_valid, flush_if, br_taken, br_resolved, wait_err, stall_id}); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset redirect_pc got %08h want 00000000", redirect_pc); end
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_directed();
    drive_branch(0, 1, 32'h0040_0010, 32'h0000_0004, 0, "beq_taken");
    drive_branch(1, 1, 32'h0000_1000, 32'h0000_0010, 0, "bne_equal");
    drive_branch(4, 3, 32'h0000_2000, 32'h0000_0010, 0, "blez_gt");
    drive_branch(7, 2, 32'h0000_3000, 32'h0000_0010, 0, "cond7_lt");
    drive_branch(0, 0, 32'h0000_3000, 32'h0000_0010, 0, "beq_default");
    drive_branch(0, 1, 32'hFFFF_FFFC, 32'h0000_0000, 0, "wrap");
    drive_branch(1, 2, 32'h0000_0010, 32'hFFFF_FFFD, 0, "neg_offset");
    drive_branch(5, 3, 32'h0001_0000, 32'h0000_0040, 2, "bgez_wait2");
    drive_branch(2, 2, 32'h0001_0100, 32'h0000_0008, MAX_WAIT, "bltz_wait_max");
  endtask

  task automatic test_overrun();
    drive_branch(3, 3, 32'h0002_0000, 32'h0000_0004, MAX_WAIT + 1, "overrun");
    drive_branch(3, 3, 32'h0002_0000, 32'h0000_0004, 0, "after_overrun");
  endtask

  task automatic test_flush_wait();
    br_valid = 1'b1; opnd_ready = 1'b0; ex_flush = 1'b0;
    br_cond = 3'd0; br_pc = 32'h0000_4000; br_offset = 32'h4; cmp_result = 2'b01;
    next_cycle();
    ex_flush = 1'b1; opnd_ready = 1'b1;
    @(negedge clk);
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL flush_wait stall_id got %0b want 0", stall_id); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (br_resolved !== 1'b0 || redirect_valid !== 1'b0 || stall_id !== 1'b0) begin errors++; $display("FAIL flush_wait after res=%0b rv=%0b stall=%0b want 0", br_resolved, redirect_valid, stall_id); end
    next_cycle();
    @(negedge clk);
    checks++; if (br_resolved !== 1'b0 || wait_err !== 1'b0) begin errors++; $display("FAIL flush_wait late res=%0b err=%0b want 0", br_resolved, wait_err); end
    next_cycle();
  endtask

  task automatic test_rst_issue();
    br_valid = 1'b1; opnd_ready = 1'b1; ex_flush = 1'b0;
    br_cond = 3'd0; br_pc = 32'h0000_5000; br_offset = 32'h8; cmp_result = 2'b01;
    next_cycle();
    idle_inputs(); rst = 1'b1;
    @(negedge clk);
    checks++; if (br_resolved !== 1'b1 || redirect_valid !== 1'b1) begin errors++; $display("FAIL rst_issue visible res=%0b rv=%0b want 1/1", br_resolved, redirect_valid); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({redirect_valid, flush_if, br_taken, br_resolved, wait_err, stall_id} !== 6'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_issue outputs got %06b pc %08h want 0", {redirect_valid, flush_if, br_taken, br_resolved, wait_err, stall_id}, redirect_pc); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    br_valid = 1'b1; opnd_ready = 1'b1; ex_flush = 1'b0;
    br_cond = 3'd3; br_pc = 32'h0000_6000; br_offset = 32'h10; cmp_result = 2'b11;
    next_cycle();
    br_cond = 3'd0; br_pc = 32'h0000_7000; br_offset = 32'h20; cmp_result = 2'b01;
    @(negedge clk);
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL b2b issue stall_id got %0b want 0", stall_id); end
    checks++; if (redirect_pc !== ref_target(32'h0000_6000, 32'h10)) begin errors++; $display("FAIL b2b first redirect_pc got %08h want %08h", redirect_pc, ref_target(32'h0000_6000, 32'h10)); end
    next_cycle();
    @(negedge clk);
    checks++; if (stall_id !== 1'b1 || br_resolved !== 1'b0) begin errors++; $display("FAIL b2b second accept stall=%0b res=%0b want 1/0", stall_id, br_resolved); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (br_resolved !== 1'b1 || redirect_pc !== ref_target(32'h0000_7000, 32'h20)) begin errors++; $display("FAIL b2b second res=%0b pc=%08h want 1/%08h", br_resolved, redirect_pc, ref_target(32'h0000_7000, 32'h20)); end
    next_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      drive_branch(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), $urandom, $urandom,
                   int'($urandom_range(0, MAX_WAIT + 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overrun();
    test_flush_wait();
    test_rst_issue();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
